// File: rtl/tournament_chooser.sv
// Tournament chooser PHT: per-slot local/global selection from saturating counters
// indexed by PC ^ global history, swept to weak-local after reset, trained from EX.
module tournament_chooser #(
  parameter int INDEX_W  = 8,
  parameter int CTR_W    = 2,
  parameter int NUM_RD   = 2,
  parameter int ADDR_LSB = 3,
  parameter int HIST_W   = 8,
  localparam int GHR_W   = (HIST_W > 0) ? HIST_W : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_RD*32-1:0]  rd_addr_i,
  input  logic [GHR_W-1:0]      rd_ghr_i,
  output logic [NUM_RD-1:0]     choice_o,
  output logic                  ready_o,
  input  logic                  upd_valid_i,
  input  logic [31:0]           upd_addr_i,
  input  logic [GHR_W-1:0]      upd_ghr_i,
  input  logic                  upd_local_ok_i,
  input  logic                  upd_global_ok_i
);

  localparam int                 DEPTH      = 1 << INDEX_W;
  localparam logic [CTR_W-1:0]   WEAK_LOCAL = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0]   CTR_MAX    = '1;
  localparam logic [CTR_W-1:0]   CTR_MIN    = '0;
  localparam logic [INDEX_W-1:0] LAST_IDX   = '1;
  localparam logic [INDEX_W-1:0] HIST_MASK  = (HIST_W == 0) ? '0 : '1;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t               state, state_nx;
  logic [INDEX_W-1:0]   sweep_ptr, sweep_nx;
  logic                 init_we;

  logic [CTR_W-1:0]     table_mem [DEPTH];

  logic                 pend_vld_p1;
  logic [INDEX_W-1:0]   pend_idx_p1;
  logic [CTR_W-1:0]     pend_val_p1;

  logic                 upd_fire_p0;
  logic [INDEX_W-1:0]   upd_idx_p0;
  logic [CTR_W-1:0]     upd_old_p0;
  logic [CTR_W-1:0]     upd_new_p0;

  logic [INDEX_W-1:0]   rd_idx_p0 [NUM_RD];
  logic [CTR_W-1:0]     rd_ctr_p0 [NUM_RD];

  logic                 unused_bits;

  function automatic logic [INDEX_W-1:0] hash_idx(input logic [31:0] addr,
                                                  input logic [GHR_W-1:0] ghr);
    return addr[ADDR_LSB +: INDEX_W] ^ (INDEX_W'(ghr) & HIST_MASK);
  endfunction

  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
    return (v == CTR_MAX) ? v : v + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] v);
    return (v == CTR_MIN) ? v : v - CTR_W'(1);
  endfunction

  // Counter moves only when exactly one component was right.
  function automatic logic [CTR_W-1:0] next_ctr(input logic [CTR_W-1:0] v,
                                                input logic local_ok,
                                                input logic global_ok);
    logic [CTR_W-1:0] r;
    r = v;
    if (local_ok && !global_ok)      r = sat_dec(v);
    else if (global_ok && !local_ok) r = sat_inc(v);
    return r;
  endfunction

  // FSM: init sweep, then ready until the next reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_INIT;
      sweep_ptr <= '0;
    end else begin
      state     <= state_nx;
      sweep_ptr <= sweep_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sweep_nx = sweep_ptr;
    init_we  = 1'b0;
    case (state)
      ST_INIT: begin
        init_we  = 1'b1;
        sweep_nx = sweep_ptr + INDEX_W'(1);
        if (sweep_ptr == LAST_IDX) state_nx = ST_READY;
      end
      ST_READY: state_nx = ST_READY;
      default:  state_nx = ST_INIT;
    endcase
  end

  assign ready_o = (state == ST_READY);

  // Stage p0: lookups and update compute, forwarding from the pending stage
  always_comb begin
    choice_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_idx_p0[k] = hash_idx(rd_addr_i[32*k +: 32], rd_ghr_i);
      rd_ctr_p0[k] = (pend_vld_p1 && (pend_idx_p1 == rd_idx_p0[k]))
                     ? pend_val_p1 : table_mem[rd_idx_p0[k]];
      choice_o[k]  = ready_o & rd_ctr_p0[k][CTR_W-1];
    end
  end

  assign upd_fire_p0 = upd_valid_i & ready_o;
  assign upd_idx_p0  = hash_idx(upd_addr_i, upd_ghr_i);
  assign upd_old_p0  = (pend_vld_p1 && (pend_idx_p1 == upd_idx_p0))
                       ? pend_val_p1 : table_mem[upd_idx_p0];
  assign upd_new_p0  = next_ctr(upd_old_p0, upd_local_ok_i, upd_global_ok_i);

  // Stage p1: pending update register
  always_ff @(posedge clk) begin
    if (!rst) pend_vld_p1 <= 1'b0;
    else      pend_vld_p1 <= upd_fire_p0;
  end

  always_ff @(posedge clk) begin
    if (upd_fire_p0) begin
      pend_idx_p1 <= upd_idx_p0;
      pend_val_p1 <= upd_new_p0;
    end
  end

  // Table write port: sweep during init, otherwise retire the pending update
  always_ff @(posedge clk) begin
    if (rst) begin
      if (init_we)          table_mem[sweep_ptr]   <= WEAK_LOCAL;
      else if (pend_vld_p1) table_mem[pend_idx_p1] <= pend_val_p1;
    end
  end

  assign unused_bits = ^{rd_addr_i, upd_addr_i, rd_ghr_i, upd_ghr_i};

endmodule

// File: tb/tb_tournament_chooser.sv
// Directed bench for tournament_chooser: per-cycle comparison against an
// effective-counter model plus hand-computed checkpoints.
module tb_tournament_chooser;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rd_addr;
  logic [7:0]  rd_ghr;
  logic [1:0]  choice;
  logic        ready;
  logic        upd_valid;
  logic [31:0] upd_addr;
  logic [7:0]  upd_ghr;
  logic        upd_lok;
  logic        upd_gok;

  int n_cmp  = 0;
  int n_fail = 0;

  int model_tbl [256];
  bit mready    = 1'b0;
  int sweep_cnt = 0;
  bit cmp_en    = 1'b0;

  always #5 clk = ~clk;

  tournament_chooser dut (
    .clk             (clk),
    .rst             (rst),
    .rd_addr_i       (rd_addr),
    .rd_ghr_i        (rd_ghr),
    .choice_o        (choice),
    .ready_o         (ready),
    .upd_valid_i     (upd_valid),
    .upd_addr_i      (upd_addr),
    .upd_ghr_i       (upd_ghr),
    .upd_local_ok_i  (upd_lok),
    .upd_global_ok_i (upd_gok)
  );

  function automatic int midx(input logic [31:0] a, input logic [7:0] g);
    return int'(((a >> 3) ^ {24'd0, g}) & 32'hff);
  endfunction

  function automatic int mupd(input int v, input logic l, input logic g);
    if (g && !l) return (v >= 3) ? 3 : v + 1;
    if (l && !g) return (v <= 0) ? 0 : v - 1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: an update is visible in full from the cycle after it is accepted.
  always @(posedge clk) begin
    if (!rst) begin
      mready    <= 1'b0;
      sweep_cnt <= 0;
    end else if (!mready) begin
      sweep_cnt <= sweep_cnt + 1;
      if (sweep_cnt == 255) begin
        mready <= 1'b1;
        for (int i = 0; i < 256; i++) model_tbl[i] <= 1;
      end
    end else if (upd_valid) begin
      model_tbl[midx(upd_addr, upd_ghr)] <= mupd(model_tbl[midx(upd_addr, upd_ghr)], upd_lok, upd_gok);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready", {31'd0, ready}, {31'd0, mready});
      for (int k = 0; k < 2; k++) begin
        logic [31:0] a;
        logic        e;
        a = rd_addr[32*k +: 32];
        e = mready && (model_tbl[midx(a, rd_ghr)] >= 2);
        check($sformatf("choice%0d", k), {31'd0, choice[k]}, {31'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic upd_n(input int n, input logic [31:0] a, input logic [7:0] g,
                       input logic l, input logic gk);
    upd_valid = 1'b1; upd_addr = a; upd_ghr = g; upd_lok = l; upd_gok = gk;
    repeat (n) tick();
    upd_valid = 1'b0; upd_lok = 1'b0; upd_gok = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rd_addr = '0; rd_ghr = '0;
    upd_valid = 1'b0; upd_addr = '0; upd_ghr = '0; upd_lok = 1'b0; upd_gok = 1'b0;
    tick(); tick();
    cmp_en = 1'b1;
    tick();
    check("rst_ready", {31'd0, ready}, 32'd0);

    // Sweep; the next edge is the first one with rst high
    rst = 1'b1;
    rd_addr = {32'h48, 32'h40};
    repeat (9) tick();
    upd_n(1, 32'h40, 8'h00, 1'b0, 1'b1);
    repeat (245) tick();
    check("init_ready_255", {31'd0, ready}, 32'd0);
    check("init_choice", {30'd0, choice}, 32'd0);
    tick();
    check("ready_256", {31'd0, ready}, 32'd1);
    check("init_upd_dropped", {30'd0, choice}, 32'd0);
    check("model_e8_weak", model_tbl[8], 32'd1);

    upd_n(1, 32'h40, 8'h00, 1'b0, 1'b1);
    check("g_win_choice", {30'd0, choice}, 32'b01);
    check("model_e8_2", model_tbl[8], 32'd2);
    upd_n(4, 32'h40, 8'h00, 1'b0, 1'b1);
    check("sat_hi", model_tbl[8], 32'd3);
    check("sat_hi_choice", {30'd0, choice}, 32'b01);
    upd_n(1, 32'h40, 8'h00, 1'b1, 1'b0);
    check("dec_from_3", model_tbl[8], 32'd2);
    check("dec_choice", {30'd0, choice}, 32'b01);
    upd_n(2, 32'h40, 8'h00, 1'b1, 1'b0);
    check("dec_to_0", model_tbl[8], 32'd0);
    check("dec_to_0_choice", {30'd0, choice}, 32'b00);
    upd_n(1, 32'h40, 8'h00, 1'b1, 1'b0);
    check("sat_lo", model_tbl[8], 32'd0);

    upd_n(2, 32'h40, 8'h00, 1'b0, 1'b1);
    upd_n(1, 32'h40, 8'h00, 1'b1, 1'b1);
    upd_n(1, 32'h40, 8'h00, 1'b0, 1'b0);
    check("equal_flags", model_tbl[8], 32'd2);
    check("equal_flags_choice", {30'd0, choice}, 32'b01);
    upd_n(1, 32'h40, 8'h00, 1'b1, 1'b0);

    // History hash: (0x40, 0x08) aliases to entry 0
    rd_addr = {32'h40, 32'h0}; rd_ghr = 8'h00;
    tick();
    check("hash_before", {30'd0, choice}, 32'b00);
    upd_n(1, 32'h40, 8'h08, 1'b0, 1'b1);
    check("hash_choice", {30'd0, choice}, 32'b01);
    check("hash_model_e0", model_tbl[0], 32'd2);

    // Back-to-back chains on entry 5
    rd_addr = {32'h28, 32'h28};
    upd_n(3, 32'h28, 8'h00, 1'b0, 1'b1);
    check("chain_up", model_tbl[5], 32'd3);
    check("chain_up_choice", {30'd0, choice}, 32'b11);
    upd_n(2, 32'h28, 8'h00, 1'b1, 1'b0);
    check("chain_down", model_tbl[5], 32'd1);
    check("chain_down_choice", {30'd0, choice}, 32'b00);

    // Reset with an update stream in flight
    upd_valid = 1'b1; upd_addr = 32'h28; upd_ghr = 8'h00; upd_lok = 1'b0; upd_gok = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    repeat (3) tick();
    upd_valid = 1'b0; upd_gok = 1'b0;
    repeat (252) tick();
    check("resweep_ready_255", {31'd0, ready}, 32'd0);
    tick();
    check("resweep_ready", {31'd0, ready}, 32'd1);
    check("resweep_choice", {30'd0, choice}, 32'b00);
    check("resweep_model_e5", model_tbl[5], 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
